// File: rtl/clock_set_controller.sv
// Clock set controller: routes the seconds/minutes/hours counter controls.
// RUN chains each counter's overflow into the next counter's count input.
// SET_HOUR / SET_MIN freeze timekeeping and turn debounced button presses
// into single increment/decrement pulses for the field being edited, while
// the edited field blinks on the display.
// No valid/ready traffic here: a button press is a one-cycle registered pulse,
// consumed in the same cycle it is visible, with no back-pressure.
module clock_set_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       sec_tick,
  input  logic       sec_over,
  input  logic       min_over,
  output logic       sec_count,
  output logic       min_count,
  output logic       hour_count,
  output logic       cnt_sign,
  output logic       sec_load,
  output logic       run,
  output logic       blank_hour,
  output logic       blank_min,
  output logic [1:0] mode_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

  // Encoding doubles as the mode_state debug/display output.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  // Button lanes: bit 0 MODE, bit 1 UP, bit 2 DOWN.
  logic [2:0]      w_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_level;
  logic [2:0]      r_level_d;
  logic [2:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [3];

  logic            w_press_mode;
  logic            w_press_up;
  logic            w_press_down;
  logic            w_edit;

  state_t          r_state;
  state_t          w_next;

  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_phase;

  assign w_raw        = {btn_down, btn_up, btn_mode};
  assign w_press_mode = r_press[0];
  assign w_press_up   = r_press[1];
  assign w_press_down = r_press[2];
  // MODE takes priority; UP and DOWN together cancel each other.
  assign w_edit       = ~w_press_mode & (w_press_up ^ w_press_down);

  // Synchronise, debounce and edge-detect all three buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      r_press   <= '0;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          // Agreement (or a bounce back) restarts the stability count.
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_level[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Mode state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and counter-control decode; the RUN carry chain is combinational.
  always_comb begin
    w_next     = r_state;
    run        = 1'b0;
    sec_count  = 1'b0;
    min_count  = 1'b0;
    hour_count = 1'b0;
    cnt_sign   = 1'b0;
    sec_load   = 1'b0;
    case (r_state)
      ST_RUN: begin
        run        = 1'b1;
        sec_count  = sec_tick;
        min_count  = sec_over;
        hour_count = min_over;
        if (w_press_mode) begin
          w_next = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR: begin
        hour_count = w_edit;
        cnt_sign   = w_edit & w_press_down;
        if (w_press_mode) begin
          w_next = ST_SET_MIN;
        end
      end
      ST_SET_MIN: begin
        min_count = w_edit;
        cnt_sign  = w_edit & w_press_down;
        if (w_press_mode) begin
          w_next   = ST_RUN;
          // Leaving SET restarts the minute from :00.
          sec_load = 1'b1;
        end
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  // Blink timer for the edited field, restarted on every mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if ((r_state == ST_RUN) || (w_next != r_state)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BL_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  assign blank_hour = (r_state == ST_SET_HOUR) & r_blink_phase;
  assign blank_min  = (r_state == ST_SET_MIN) & r_blink_phase;
  assign mode_state = r_state;

endmodule

// File: tb/tb_clock_set_controller.sv
// Testbench for clock_set_controller.
// Button waveforms are planned into per-cycle arrays; each planned clean rise
// schedules a press DEBOUNCE+3 cycles later. A cycle-level model derives every
// output from the mode, the scheduled presses and the time spent in the mode.
module tb_clock_set_controller;

  localparam int D    = 4;
  localparam int B    = 8;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       sec_tick = 1'b0;
  logic       sec_over = 1'b0;
  logic       min_over = 1'b0;
  logic       sec_count, min_count, hour_count, cnt_sign, sec_load, run;
  logic       blank_hour, blank_min;
  logic [1:0] mode_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit raw_m [MAXC];
  bit raw_u [MAXC];
  bit raw_d [MAXC];
  bit sch_m [MAXC];
  bit sch_u [MAXC];
  bit sch_d [MAXC];

  logic [1:0] m_state   = 2'd0;
  int         m_entered = 0;

  // Vector layout: {mode_state, run, sec, min, hour, sign, load, blank_hour, blank_min}
  logic [9:0] exp_q [$];
  logic [9:0] obs_v;

  clock_set_controller #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_CYCLES   (B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .sec_tick  (sec_tick),
    .sec_over  (sec_over),
    .min_over  (min_over),
    .sec_count (sec_count),
    .min_count (min_count),
    .hour_count(hour_count),
    .cnt_sign  (cnt_sign),
    .sec_load  (sec_load),
    .run       (run),
    .blank_hour(blank_hour),
    .blank_min (blank_min),
    .mode_state(mode_state)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [2:0] rs();
    return 3'($urandom_range(0, 7));
  endfunction

  // Plan a clean rise at cycle t on the buttons in mud = {mode, up, down}.
  task automatic plan(input logic [2:0] mud, input int t, input int hold);
    for (int i = t; i < t + hold; i++) begin
      if (mud[2]) raw_m[i] = 1'b1;
      if (mud[1]) raw_u[i] = 1'b1;
      if (mud[0]) raw_d[i] = 1'b1;
    end
    if (mud[2]) sch_m[t + D + 3] = 1'b1;
    if (mud[1]) sch_u[t + D + 3] = 1'b1;
    if (mud[0]) sch_d[t + D + 3] = 1'b1;
  endtask

  // Plan an operation at t and return the earliest start of the next one.
  task automatic plan_op(input logic [2:0] mud, input int t, output int t_next);
    int hold;
    hold = $urandom_range(D + 1, D + 5);
    plan(mud, t, hold);
    t_next = t + hold + $urandom_range(D + 2, D + 6);
  endtask

  // Driver + reference model for one clock cycle: drive inputs after the
  // falling edge, sample outputs before the next rising edge.
  task automatic cycle(input logic [2:0] side);
    logic pm, pu, pd, edit, ph;
    logic es, emn, eh, esg, eld, ebh, ebm;
    @(negedge clk);
    btn_mode = raw_m[cyc];
    btn_up   = raw_u[cyc];
    btn_down = raw_d[cyc];
    {sec_tick, sec_over, min_over} = side;
    #2;
    obs_v = {mode_state, run, sec_count, min_count, hour_count, cnt_sign,
             sec_load, blank_hour, blank_min};
    pm = sch_m[cyc];
    pu = sch_u[cyc];
    pd = sch_d[cyc];
    if (m_state == 2'd0) begin
      es = side[2]; emn = side[1]; eh = side[0];
      esg = 1'b0; eld = 1'b0; ebh = 1'b0; ebm = 1'b0;
    end else begin
      edit = !pm && (pu != pd);
      ph   = (((cyc - m_entered) / B) % 2) == 1;
      es   = 1'b0;
      eh   = (m_state == 2'd1) && edit;
      emn  = (m_state == 2'd2) && edit;
      esg  = edit && pd;
      eld  = (m_state == 2'd2) && pm;
      ebh  = (m_state == 2'd1) && ph;
      ebm  = (m_state == 2'd2) && ph;
    end
    exp_q.push_back({m_state, (m_state == 2'd0), es, emn, eh, esg, eld, ebh, ebm});
    if (pm) begin
      m_state   = (m_state == 2'd2) ? 2'd0 : m_state + 2'd1;
      m_entered = cyc + 1;
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mode_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mode got=%0d exp=0", mode_state);
    end
    checks++;
    if (run !== 1'b1) begin
      failures++;
      $display("FAIL reset_run got=%b exp=1", run);
    end
    checks++;
    if ({sec_count, min_count, hour_count, cnt_sign, sec_load, blank_hour, blank_min} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000",
               {sec_count, min_count, hour_count, cnt_sign, sec_load, blank_hour, blank_min});
    end
    rst = 1'b0;
  endtask

  task automatic test_run_chain();
    logic [2:0] pat [6];
    logic [9:0] e;
    pat = '{3'b111, 3'b000, 3'b101, 3'b010, 3'b111, 3'b100};
    for (int k = 0; k < 6; k++) begin
      cycle(pat[k]);
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL run_chain cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
      if (k == 0) begin
        checks++;
        if ({sec_count, min_count, hour_count, cnt_sign} !== 4'b1110) begin
          failures++;
          $display("FAIL run_chain_all got=%b exp=1110",
                   {sec_count, min_count, hour_count, cnt_sign});
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [9:0] e;
    int t, s, pulses, pulse_at;
    // Enter SET_HOUR so an UP press is visible as an hour_count pulse.
    plan_op(3'b100, cyc + 2, t);
    while (cyc < t) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL bounce_enter cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
    end
    s = cyc + 2;
    raw_u[s]     = 1'b1;
    raw_u[s + 1] = 1'b0;
    for (int i = s + 2; i < s + 14; i++) raw_u[i] = 1'b1;
    sch_u[s + 2 + 7] = 1'b1;
    pulses   = 0;
    pulse_at = -1;
    while (cyc < s + 24) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
      if (hour_count === 1'b1) begin
        pulses++;
        pulse_at = cyc - 1;
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != s + 9) begin
      failures++;
      $display("FAIL bounce_press got=%0d@%0d exp=1@%0d", pulses, pulse_at, s + 9);
    end
  endtask

  task automatic test_edit_sequence();
    logic [2:0] ops [8];
    logic [9:0] e;
    int t, hd, hu, mu, md, ld, sc;
    // Return to RUN first, from SET_HOUR left by the previous test.
    ops = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b100, 3'b010};
    t = cyc + 2;
    plan_op(3'b100, t, t);
    plan_op(3'b100, t, t);
    while (cyc < t) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL edit_prep cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
    end
    // MODE; DOWN x3; MODE; UP x2; MODE
    ops = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b010, 3'b100};
    t = cyc + 2;
    for (int k = 0; k < 8; k++) plan_op(ops[k], t, t);
    hd = 0; hu = 0; mu = 0; md = 0; ld = 0; sc = 0;
    while (cyc < t + D + 4) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL edit_seq cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
      if (run === 1'b0) begin
        if (hour_count === 1'b1 && cnt_sign === 1'b1) hd++;
        if (hour_count === 1'b1 && cnt_sign === 1'b0) hu++;
        if (min_count === 1'b1 && cnt_sign === 1'b0) mu++;
        if (min_count === 1'b1 && cnt_sign === 1'b1) md++;
        if (sec_count === 1'b1) sc++;
      end
      if (sec_load === 1'b1) ld++;
    end
    checks++;
    if (hd != 3 || hu != 0 || mu != 2 || md != 0 || ld != 1 || sc != 0) begin
      failures++;
      $display("FAIL edit_counts got=hd%0d hu%0d mu%0d md%0d ld%0d sc%0d exp=hd3 hu0 mu2 md0 ld1 sc0",
               hd, hu, mu, md, ld, sc);
    end
    checks++;
    if (mode_state !== 2'd0) begin
      failures++;
      $display("FAIL edit_end_mode got=%0d exp=0", mode_state);
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] e;
    int t, hp, mp;
    // MODE into SET_HOUR, then MODE+UP together, then UP+DOWN in SET_MIN, then MODE.
    t = cyc + 2;
    plan_op(3'b100, t, t);
    plan_op(3'b110, t, t);
    plan_op(3'b011, t, t);
    plan_op(3'b100, t, t);
    hp = 0;
    mp = 0;
    while (cyc < t + D + 4) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL simul cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
      if (run === 1'b0 && hour_count === 1'b1) hp++;
      if (run === 1'b0 && min_count === 1'b1) mp++;
    end
    checks++;
    if (hp != 0 || mp != 0 || mode_state !== 2'd0) begin
      failures++;
      $display("FAIL simul_pulses got=h%0d m%0d mode%0d exp=h0 m0 mode0", hp, mp, mode_state);
    end
  endtask

  task automatic test_blink();
    logic [9:0] e;
    logic prev;
    int t, toggles, first_tog, bm_seen;
    plan_op(3'b100, cyc + 2, t);
    for (int k = 0; k < 60 && !(m_state == 2'd1 && cyc == m_entered); k++) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL blink_enter cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
    end
    toggles   = 0;
    first_tog = -1;
    bm_seen   = 0;
    prev      = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL blink cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
      if (n > 0 && blank_hour !== prev) begin
        toggles++;
        if (first_tog < 0) first_tog = n;
      end
      if (blank_min !== 1'b0) bm_seen++;
      prev = blank_hour;
    end
    checks++;
    if (toggles != 4 || first_tog != 8 || bm_seen != 0) begin
      failures++;
      $display("FAIL blink_toggles got=%0d first=%0d bm=%0d exp=4 first=8 bm=0",
               toggles, first_tog, bm_seen);
    end
    t = cyc + 2;
    plan_op(3'b100, t, t);
    plan_op(3'b100, t, t);
    while (cyc < t + D + 4) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL blink_exit cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] kinds [6];
    logic [9:0] e;
    int t;
    kinds = '{3'b100, 3'b010, 3'b001, 3'b011, 3'b110, 3'b101};
    t = cyc + 2;
    for (int k = 0; k < 60; k++) begin
      plan_op(kinds[$urandom_range(0, 5)], t, t);
    end
    while (cyc < t + D + 4) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
    end
  endtask

  task automatic test_reset_mid_edit();
    logic [9:0] e;
    int t;
    bit found;
    t = cyc + 2;
    if (m_state == 2'd0) plan_op(3'b100, t, t);
    if (m_state != 2'd2) plan_op(3'b100, t, t);
    while (cyc < t + D + 4) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL rst_prep cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
    end
    found = 1'b0;
    for (int k = 0; k < 3 * B && !found; k++) begin
      cycle(3'b000);
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL rst_wait cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
      if (blank_min === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_blank_min got=0 exp=1 within %0d cycles", 3 * B);
    end
    // Assert reset between clock edges and look before any edge arrives.
    rst = 1'b1;
    #1;
    checks++;
    if ({mode_state, run, blank_hour, blank_min, sec_load} !== 6'b001000) begin
      failures++;
      $display("FAIL rst_mid_edit got=%b exp=001000",
               {mode_state, run, blank_hour, blank_min, sec_load});
    end
    for (int i = cyc; i < MAXC; i++) begin
      raw_m[i] = 1'b0; raw_u[i] = 1'b0; raw_d[i] = 1'b0;
      sch_m[i] = 1'b0; sch_u[i] = 1'b0; sch_d[i] = 1'b0;
    end
    m_state = 2'd0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    // Timekeeping resumes and a fresh MODE press still works.
    plan_op(3'b100, cyc + 2, t);
    while (cyc < t + D + 4) begin
      cycle(rs());
      e = exp_q.pop_front();
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL rst_after cyc=%0d got=%b exp=%b", cyc, obs_v, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_chain();
    test_bounce();
    test_edit_sequence();
    test_simultaneous();
    test_blink();
    test_random();
    test_reset_mid_edit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
